stereo_frame_source: RTL and testbench

//  Captures one left and one right camera frame, each WIDTH x HEIGHT 8-bit pixels, into two on-chip buffers.

---
 rtl/stereo_frame_source_if.sv | 27 ++
 rtl/stereo_frame_source.sv | 146 ++++++++++++++
 tb/tb_stereo_frame_source.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/stereo_frame_source_if.sv
// Camera write side and disparity-engine read side of the stereo frame buffer.
// master = the frame source itself, slave = camera/engine (or bench) side.
interface stereo_frame_source_if;
    logic       cam_sof;
    logic       cam_valid;
    logic       cam_sel;
    logic [7:0] cam_data;
    logic       rd_en;
    logic       rd_sel;
    logic [7:0] image_data;
    logic       rd_valid;
    logic       rd_last;
    logic       buffer_ready;
    logic       left_done;
    logic       right_done;
    logic       overrun;

    modport master (
        input  cam_sof, cam_valid, cam_sel, cam_data, rd_en, rd_sel,
        output image_data, rd_valid, rd_last, buffer_ready, left_done, right_done, overrun
    );

    modport slave (
        output cam_sof, cam_valid, cam_sel, cam_data, rd_en, rd_sel,
        input  image_data, rd_valid, rd_last, buffer_ready, left_done, right_done, overrun
    );
endinterface

// File: rtl/stereo_frame_source.sv
// Captures a left and right frame, then serves them in raster order; read data 1 cycle after rd_en.
// No camera backpressure: beats arriving while frames are locked are dropped and flagged on overrun.
module stereo_frame_source #(
    parameter int WIDTH  = 20,
    parameter int HEIGHT = 7,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    stereo_frame_source_if.master bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] N_A    = ADDR_W'(WIDTH * HEIGHT);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

    typedef enum logic [1:0] {ST_CAPTURE, ST_READY, ST_DRAIN} state_t;
    state_t state_q, state_d;

    logic [1:0][ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [1:0]             armed_q, armed_d, done_q, done_d;
    logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, overrun_q, overrun_d;
    logic img_seen_q, img_seen_d, out_sel_q, out_sel_d;

    logic              locked, buffer_ready, rd_fire, drain_done, wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        mem_l [DEPTH];
    logic [7:0]        mem_r [DEPTH];
    logic [7:0]        ram_l_rd, ram_r_rd;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_CAPTURE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CAPTURE: if (&done_q)    state_d = ST_READY;
            ST_READY:   if (rd_fire)    state_d = ST_DRAIN;
            ST_DRAIN:   if (drain_done) state_d = ST_CAPTURE;
            default:                    state_d = ST_CAPTURE;
        endcase
    end

    // Outputs of the FSM; the cycle where both frames just completed is already locked
    always_comb begin
        buffer_ready = (state_q != ST_CAPTURE);
        locked       = buffer_ready || (&done_q);
        rd_fire      = bus.rd_en && buffer_ready && (rp_q[bus.rd_sel] != N_A);
        drain_done   = (state_q == ST_DRAIN) && rd_valid_q && rd_last_q &&
                       (rp_q[0] == N_A) && (rp_q[1] == N_A);
    end

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        armed_d    = armed_q;
        done_d     = done_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        overrun_d  = 1'b0;
        img_seen_d = img_seen_q;
        out_sel_d  = out_sel_q;
        wr_en      = 1'b0;
        wr_addr    = bus.cam_sof ? '0 : wp_q[bus.cam_sel];

        if (locked) begin
            overrun_d = bus.cam_valid || bus.cam_sof;
        end else begin
            if (bus.cam_sof) begin
                wp_d[bus.cam_sel]    = '0;
                armed_d[bus.cam_sel] = 1'b1;
                done_d[bus.cam_sel]  = 1'b0;
            end
            if (bus.cam_valid && (bus.cam_sof || armed_q[bus.cam_sel])) begin
                wr_en             = 1'b1;
                wp_d[bus.cam_sel] = wr_addr + ONE_A;
                if (wr_addr == LAST_A) begin
                    done_d[bus.cam_sel]  = 1'b1;
                    armed_d[bus.cam_sel] = 1'b0;
                end
            end
        end

        if (rd_fire) begin
            rp_d[bus.rd_sel] = rp_q[bus.rd_sel] + ONE_A;
            rd_valid_d       = 1'b1;
            rd_last_d        = (rp_q[bus.rd_sel] == LAST_A);
            img_seen_d       = 1'b1;
            out_sel_d        = bus.rd_sel;
        end

        if (drain_done) begin
            rp_d    = '0;
            armed_d = '0;
            done_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            armed_q    <= '0;
            done_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            overrun_q  <= 1'b0;
            img_seen_q <= 1'b0;
            out_sel_q  <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            armed_q    <= armed_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            overrun_q  <= overrun_d;
            img_seen_q <= img_seen_d;
            out_sel_q  <= out_sel_d;
        end
    end

    // Frame RAMs: one write port, one registered read port each, no reset
    always_ff @(posedge clk) begin
        if (wr_en && !bus.cam_sel) mem_l[wr_addr] <= bus.cam_data;
        if (rd_fire && !bus.rd_sel) ram_l_rd <= mem_l[rp_q[0]];
    end

    always_ff @(posedge clk) begin
        if (wr_en && bus.cam_sel) mem_r[wr_addr] <= bus.cam_data;
        if (rd_fire && bus.rd_sel) ram_r_rd <= mem_r[rp_q[1]];
    end

    // img_seen masks the unreset RAM read registers so image_data is 0 out of reset
    assign bus.image_data   = img_seen_q ? (out_sel_q ? ram_r_rd : ram_l_rd) : 8'h00;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_last      = rd_last_q;
    assign bus.buffer_ready = buffer_ready;
    assign bus.left_done    = done_q[0];
    assign bus.right_done   = done_q[1];
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_stereo_frame_source.sv
// Directed + randomized bench for stereo_frame_source against a queue-based frame model.
module tb_stereo_frame_source;
    localparam int W = 20;
    localparam int H = 7;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stereo_frame_source_if bus();

    stereo_frame_source #(.WIDTH(W), .HEIGHT(H), .ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: each captured frame is a queue of pixels, reads index into it
    logic [7:0] fl[$];
    logic [7:0] fr[$];
    bit         m_arm[2];
    bit         m_done[2];
    int         m_rp[2];
    bit         m_ready, m_rdv, m_rdl, m_ovr;
    logic [7:0] m_img;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ".image_data"}, bus.image_data, m_img);
        chk({ph, ".rd_valid"}, 8'(bus.rd_valid), 8'(m_rdv));
        chk({ph, ".rd_last"}, 8'(bus.rd_last), 8'(m_rdl));
        chk({ph, ".buffer_ready"}, 8'(bus.buffer_ready), 8'(m_ready));
        chk({ph, ".left_done"}, 8'(bus.left_done), 8'(m_done[0]));
        chk({ph, ".right_done"}, 8'(bus.right_done), 8'(m_done[1]));
        chk({ph, ".overrun"}, 8'(bus.overrun), 8'(m_ovr));
    endtask

    task automatic model_reset();
        fl.delete();
        fr.delete();
        m_arm   = '{1'b0, 1'b0};
        m_done  = '{1'b0, 1'b0};
        m_rp    = '{0, 0};
        m_ready = 1'b0;
        m_rdv   = 1'b0;
        m_rdl   = 1'b0;
        m_ovr   = 1'b0;
        m_img   = 8'h00;
    endtask

    task automatic model_step(input bit sof, input bit valid, input bit sel,
                              input logic [7:0] data, input bit rden, input bit rdsel);
        bit fin, go;
        fin   = m_ready && m_rdv && m_rdl && (m_rp[0] == N) && (m_rp[1] == N);
        go    = !m_ready && m_done[0] && m_done[1];
        m_ovr = (m_ready || go) && (sof || valid);
        m_rdv = 1'b0;
        m_rdl = 1'b0;
        if (m_ready && rden && m_rp[rdsel] < N) begin
            m_img = rdsel ? fr[m_rp[1]] : fl[m_rp[0]];
            m_rdv = 1'b1;
            m_rdl = (m_rp[rdsel] == N - 1);
            m_rp[rdsel]++;
        end
        if (!m_ready && !go) begin
            if (sof) begin
                if (sel) fr.delete(); else fl.delete();
                m_arm[sel]  = 1'b1;
                m_done[sel] = 1'b0;
            end
            if (valid && m_arm[sel]) begin
                if (sel) fr.push_back(data); else fl.push_back(data);
                if ((sel ? fr.size() : fl.size()) == N) begin
                    m_done[sel] = 1'b1;
                    m_arm[sel]  = 1'b0;
                end
            end
        end
        if (go) m_ready = 1'b1;
        if (fin) begin
            m_ready = 1'b0;
            m_done  = '{1'b0, 1'b0};
            m_arm   = '{1'b0, 1'b0};
            m_rp    = '{0, 0};
        end
    endtask

    task automatic cyc(input bit sof, input bit valid, input bit sel,
                       input logic [7:0] data, input bit rden, input bit rdsel);
        bus.cam_sof   = sof;
        bus.cam_valid = valid;
        bus.cam_sel   = sel;
        bus.cam_data  = data;
        bus.rd_en     = rden;
        bus.rd_sel    = rdsel;
        @(posedge clk);
        #1;
        model_step(sof, valid, sel, data, rden, rdsel);
        check_all("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    function automatic logic [7:0] pix(input int mode, input int i);
        if (mode == 0)      return 8'(i);
        else if (mode == 1) return 8'(255 - i);
        else                return 8'($urandom);
    endfunction

    task automatic send_frame(input bit sel, input int mode, input bit sof_first,
                              input bit gaps, input int cnt);
        int start;
        start = 0;
        if (sof_first) begin
            cyc(1'b1, 1'b1, sel, pix(mode, 0), 1'b0, 1'b0);
            start = 1;
        end else begin
            cyc(1'b1, 1'b0, sel, 8'h00, 1'b0, 1'b0);
        end
        for (int i = start; i < cnt; i++) begin
            if (gaps && $urandom_range(3) == 0) cyc(1'b0, 1'b0, sel, 8'h00, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, sel, pix(mode, i), 1'b0, 1'b0);
        end
    endtask

    task automatic read_side(input bit side, input int cnt);
        for (int i = 0; i < cnt; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, side);
    endtask

    task automatic random_drain();
        for (int k = 0; k < 3000 && m_ready; k++)
            cyc(1'b0, 1'b0, 1'b0, 8'h00, $urandom_range(3) != 0, 1'($urandom_range(1)));
        chk("drain_exit.buffer_ready", 8'(bus.buffer_ready), 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all("reset_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset_release");
    endtask

    initial begin
        bus.cam_sof   = 1'b0;
        bus.cam_valid = 1'b0;
        bus.cam_sel   = 1'b0;
        bus.cam_data  = 8'h00;
        bus.rd_en     = 1'b0;
        bus.rd_sel    = 1'b0;
        model_reset();
        #12;
        check_all("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Unarmed beats are ignored without overrun
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0);

        // Ramp frames: left 0..139 (separate sof), right 255-addr (sof with first pixel)
        send_frame(1'b0, 0, 1'b0, 1'b0, N);
        send_frame(1'b1, 1, 1'b1, 1'b0, N);
        idle(2);

        // Camera beats while locked only pulse overrun
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'($urandom_range(1)), 8'hAA, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        idle(1);

        // Drain left, over-read exhausted left, then drain right
        read_side(1'b0, N);
        read_side(1'b0, 3);
        read_side(1'b1, N);
        idle(2);

        // rd_en during capture does nothing
        read_side(1'b0, 4);

        // Restart mid-frame: partial 50 discarded, random right frame with gaps
        send_frame(1'b0, 2, 1'b0, 1'b1, 50);
        send_frame(1'b0, 2, 1'b0, 1'b1, N);
        send_frame(1'b1, 2, 1'b1, 1'b1, N);
        idle(1);
        random_drain();
        idle(2);

        // Reset in the middle of a drain, then sof-less beats are ignored
        send_frame(1'b1, 2, 1'b0, 1'b0, N);
        send_frame(1'b0, 2, 1'b1, 1'b0, N);
        idle(1);
        read_side(1'b0, 30);
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        read_side(1'b0, 2);

        // One more full random round after reset
        send_frame(1'b0, 2, 1'b1, 1'b1, N);
        send_frame(1'b1, 2, 1'b0, 1'b1, N);
        idle(1);
        random_drain();
        idle(2);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
